sdma_multi_ch_ctrl: RTL and testbench

Parametrised multi-channel SDMA request controller inside the FPGA IP, driven from the Wishbone bus of the AHB-to-FPGA bridge. Replaces the single fixed SDMA_Req/Done/Active hookup with up to 4 independent channels. Each channel has a programmable transfer count and optional auto-reload, and reports per-channel done status to a maskable interrupt line that feeds FB_msg_out.

---
 rtl/sdma_multi_ch_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_sdma_multi_ch_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdma_multi_ch_ctrl.sv
// Multi-channel SDMA request controller with Wishbone register file and a maskable done interrupt.
// Latency: 2-cycle bus access and registered outputs; backpressure: none, ACK always follows a request by one cycle.
module sdma_multi_ch_ctrl #(
    parameter int NUM_CH     = 4,
    parameter int CNT_W      = 16,
    parameter int ADDR_WIDTH = 7
) (
    input  logic                  WB_CLK,
    input  logic                  WB_RST,
    input  logic [ADDR_WIDTH-1:0] WBs_ADR,
    input  logic                  WBs_CYC,
    input  logic                  WBs_STB,
    input  logic                  WBs_WE,
    input  logic [3:0]            WBs_BYTE_STB,
    input  logic [31:0]           WBs_WR_DAT,
    output logic [31:0]           WBs_RD_DAT,
    output logic                  WBs_ACK,
    output logic [NUM_CH-1:0]     SDMA_Req_o,
    input  logic [NUM_CH-1:0]     SDMA_Active_i,
    input  logic [NUM_CH-1:0]     SDMA_Done_i,
    output logic                  Done_Intr_o,
    output logic                  Busy_o
);

    localparam int WORD_W = ADDR_WIDTH - 2;

    typedef enum logic [1:0] {
        CH_IDLE   = 2'd0,
        CH_REQ    = 2'd1,
        CH_ACTIVE = 2'd2
    } ch_state_t;

    logic [WORD_W-1:0] word_idx;
    logic              bus_acc;
    logic              wr_en;
    logic              rd_en;
    logic              wr_status;
    logic              wr_mask;
    logic [NUM_CH-1:0] wr_ctrl;
    logic [NUM_CH-1:0] wr_count;
    logic [NUM_CH-1:0] start_cmd;
    logic [NUM_CH-1:0] abort_cmd;
    logic [NUM_CH-1:0] pend_clr;
    logic [NUM_CH-1:0] pend_set;
    logic [NUM_CH-1:0] busy_vec;
    logic [31:0]       rd_mux;

    ch_state_t         state_q  [NUM_CH];
    ch_state_t         state_d  [NUM_CH];
    logic [CNT_W-1:0]  rem_q    [NUM_CH];
    logic [CNT_W-1:0]  rem_d    [NUM_CH];
    logic [CNT_W-1:0]  reload_q [NUM_CH];
    logic [NUM_CH-1:0] auto_q;
    logic [NUM_CH-1:0] pend_q;
    logic [NUM_CH-1:0] mask_q;

    logic unused_bits;
    assign unused_bits = ^{WBs_ADR[1:0], WBs_BYTE_STB, WBs_WR_DAT};

    assign word_idx = WBs_ADR[ADDR_WIDTH-1:2];
    assign bus_acc  = WBs_CYC & WBs_STB & ~WBs_ACK;
    assign wr_en    = bus_acc & WBs_WE;
    assign rd_en    = bus_acc & ~WBs_WE;

    always_comb begin
        wr_status = wr_en && (word_idx == WORD_W'(0));
        wr_mask   = wr_en && (word_idx == WORD_W'(1));
        wr_ctrl   = '0;
        wr_count  = '0;
        start_cmd = '0;
        abort_cmd = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            wr_ctrl[ch]   = wr_en && (word_idx == WORD_W'(2 + 2 * ch));
            wr_count[ch]  = wr_en && (word_idx == WORD_W'(3 + 2 * ch));
            start_cmd[ch] = wr_ctrl[ch] & WBs_BYTE_STB[0] & WBs_WR_DAT[0];
            abort_cmd[ch] = wr_ctrl[ch] & WBs_BYTE_STB[0] & WBs_WR_DAT[2];
        end
        pend_clr = (wr_status && WBs_BYTE_STB[0]) ? WBs_WR_DAT[NUM_CH-1:0] : '0;
    end

    // Done seen in REQ counts as an implicit Active, so REQ and ACTIVE share the completion path.
    always_comb begin
        pend_set = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            state_d[ch] = state_q[ch];
            rem_d[ch]   = rem_q[ch];
            if (abort_cmd[ch]) begin
                state_d[ch] = CH_IDLE;
            end else begin
                unique case (state_q[ch])
                    CH_IDLE: begin
                        if (start_cmd[ch] && (reload_q[ch] != '0)) begin
                            rem_d[ch]   = reload_q[ch];
                            state_d[ch] = CH_REQ;
                        end
                    end
                    CH_REQ, CH_ACTIVE: begin
                        if (SDMA_Done_i[ch]) begin
                            if (rem_q[ch] > CNT_W'(1)) begin
                                rem_d[ch]   = rem_q[ch] - CNT_W'(1);
                                state_d[ch] = CH_REQ;
                            end else begin
                                pend_set[ch] = 1'b1;
                                if (auto_q[ch] && (reload_q[ch] != '0)) begin
                                    rem_d[ch]   = reload_q[ch];
                                    state_d[ch] = CH_REQ;
                                end else begin
                                    rem_d[ch]   = '0;
                                    state_d[ch] = CH_IDLE;
                                end
                            end
                        end else if ((state_q[ch] == CH_REQ) && SDMA_Active_i[ch]) begin
                            state_d[ch] = CH_ACTIVE;
                        end
                    end
                    default: state_d[ch] = CH_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        busy_vec   = '0;
        SDMA_Req_o = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            busy_vec[ch]   = (state_q[ch] != CH_IDLE);
            SDMA_Req_o[ch] = (state_q[ch] == CH_REQ);
        end
    end

    always_comb begin
        rd_mux = '0;
        if (word_idx == WORD_W'(0)) begin
            rd_mux[NUM_CH-1:0] = pend_q;
        end else if (word_idx == WORD_W'(1)) begin
            rd_mux[NUM_CH-1:0] = mask_q;
        end
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (word_idx == WORD_W'(2 + 2 * ch)) begin
                rd_mux[1:0] = {auto_q[ch], busy_vec[ch]};
            end
            if (word_idx == WORD_W'(3 + 2 * ch)) begin
                rd_mux[CNT_W-1:0] = rem_q[ch];
            end
        end
    end

    always_ff @(posedge WB_CLK) begin
        if (WB_RST) begin
            WBs_ACK     <= 1'b0;
            WBs_RD_DAT  <= '0;
            pend_q      <= '0;
            mask_q      <= '0;
            auto_q      <= '0;
            Done_Intr_o <= 1'b0;
            Busy_o      <= 1'b0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                state_q[ch]  <= CH_IDLE;
                rem_q[ch]    <= '0;
                reload_q[ch] <= '0;
            end
        end else begin
            WBs_ACK    <= bus_acc;
            WBs_RD_DAT <= rd_en ? rd_mux : '0;
            // Hardware set is OR-ed in after the clear so a coincident W1C cannot lose an event.
            pend_q     <= (pend_q & ~pend_clr) | pend_set;
            if (wr_mask && WBs_BYTE_STB[0]) begin
                mask_q <= WBs_WR_DAT[NUM_CH-1:0];
            end
            for (int ch = 0; ch < NUM_CH; ch++) begin
                state_q[ch] <= state_d[ch];
                rem_q[ch]   <= rem_d[ch];
                if (wr_ctrl[ch] && WBs_BYTE_STB[0]) begin
                    auto_q[ch] <= WBs_WR_DAT[1];
                end
                if (wr_count[ch]) begin
                    for (int b = 0; b < CNT_W; b++) begin
                        if (WBs_BYTE_STB[b / 8]) begin
                            reload_q[ch][b] <= WBs_WR_DAT[b];
                        end
                    end
                end
            end
            Done_Intr_o <= |(pend_q & mask_q);
            Busy_o      <= |busy_vec;
        end
    end

endmodule

// File: tb/tb_sdma_multi_ch_ctrl.sv
// Bench for sdma_multi_ch_ctrl: a 4-channel instance and a 1-channel/4-bit instance,
// randomized SDMA handshakes checked against a transaction-level channel model.
module tb_sdma_multi_ch_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        tgt = 1'b0;
    logic [6:0]  adr = '0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  bs = '0;
    logic [31:0] wdat = '0;

    logic [31:0] rd_m, rd_s;
    logic        ack_m, ack_s, intr_m, intr_s, busy_m, busy_s;
    logic [3:0]  req_m;
    logic [3:0]  act_m = '0, done_m = '0;
    logic [0:0]  req_s;
    logic [0:0]  act_s = '0, done_s = '0;

    sdma_multi_ch_ctrl #(.NUM_CH(4), .CNT_W(16), .ADDR_WIDTH(7)) u_main (
        .WB_CLK(clk), .WB_RST(rst), .WBs_ADR(adr), .WBs_CYC(cyc & ~tgt), .WBs_STB(stb & ~tgt),
        .WBs_WE(we), .WBs_BYTE_STB(bs), .WBs_WR_DAT(wdat), .WBs_RD_DAT(rd_m), .WBs_ACK(ack_m),
        .SDMA_Req_o(req_m), .SDMA_Active_i(act_m), .SDMA_Done_i(done_m),
        .Done_Intr_o(intr_m), .Busy_o(busy_m)
    );

    sdma_multi_ch_ctrl #(.NUM_CH(1), .CNT_W(4), .ADDR_WIDTH(7)) u_small (
        .WB_CLK(clk), .WB_RST(rst), .WBs_ADR(adr), .WBs_CYC(cyc & tgt), .WBs_STB(stb & tgt),
        .WBs_WE(we), .WBs_BYTE_STB(bs), .WBs_WR_DAT(wdat), .WBs_RD_DAT(rd_s), .WBs_ACK(ack_s),
        .SDMA_Req_o(req_s), .SDMA_Active_i(act_s), .SDMA_Done_i(done_s),
        .Done_Intr_o(intr_s), .Busy_o(busy_s)
    );

    int checks = 0;
    int errors = 0;

    // Request rising-edge counters, sampled on the inactive edge.
    int         rise_m [4] = '{default: 0};
    int         rise_s = 0;
    logic [3:0] prev_m = '0;
    logic       prev_s = 1'b0;
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) if (req_m[i] && !prev_m[i]) rise_m[i] <= rise_m[i] + 1;
        if (req_s[0] && !prev_s) rise_s <= rise_s + 1;
        prev_m <= req_m;
        prev_s <= req_s[0];
    end

    // Channel model: reload value, remaining count, busy flag, auto flag, pending and mask.
    int         m_reload [4];
    int         m_rem    [4];
    bit         m_busy   [4];
    bit         m_auto   [4];
    logic [3:0] m_pend, m_mask;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_reload[i] = 0; m_rem[i] = 0; m_busy[i] = 0; m_auto[i] = 0;
        end
        m_pend = '0; m_mask = '0;
    endtask

    task automatic model_done(input int ch);
        if (m_rem[ch] > 1) begin
            m_rem[ch] = m_rem[ch] - 1;
        end else begin
            m_pend[ch] = 1'b1;
            if (m_auto[ch] && m_reload[ch] != 0) m_rem[ch] = m_reload[ch];
            else begin m_rem[ch] = 0; m_busy[ch] = 0; end
        end
    endtask

    task automatic bus(input bit t, input bit w, input int addr, input logic [31:0] d,
                       input logic [3:0] be, output logic [31:0] q);
        int n;
        tgt = t; adr = addr[6:0]; we = w; wdat = d; bs = be; cyc = 1'b1; stb = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            done_m = '0;
            n++;
        end while (!(t ? ack_s : ack_m) && n < 4);
        if (!(t ? ack_s : ack_m)) chk("ack_timeout", 32'(t ? ack_s : ack_m), 32'd1);
        q = t ? rd_s : rd_m;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; bs = '0;
    endtask

    task automatic wr(input int addr, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] q;
        bus(1'b0, 1'b1, addr, d, be, q);
    endtask

    task automatic rd_chk(input string tag, input bit t, input int addr, input logic [31:0] exp);
        logic [31:0] q;
        bus(t, 1'b0, addr, 32'd0, 4'h0, q);
        chk(tag, q, exp);
    endtask

    task automatic set_count(input int ch, input int v, input logic [3:0] be);
        wr(12 + 8 * ch, v, be);
        if (be[0]) m_reload[ch] = (m_reload[ch] & 32'hFF00) | (v & 32'h00FF);
        if (be[1]) m_reload[ch] = (m_reload[ch] & 32'h00FF) | (v & 32'hFF00);
    endtask

    task automatic ctrl(input int ch, input logic [31:0] v);
        wr(8 + 8 * ch, v, 4'hF);
        m_auto[ch] = v[1];
        if (v[2]) m_busy[ch] = 0;
        else if (v[0] && !m_busy[ch] && m_reload[ch] != 0) begin
            m_busy[ch] = 1; m_rem[ch] = m_reload[ch];
        end
    endtask

    task automatic w1c(input logic [3:0] v);
        wr(0, 32'(v), 4'hF);
        m_pend = m_pend & ~v;
    endtask

    task automatic check_ch(input int ch);
        rd_chk("ch_ctrl", 1'b0, 8 + 8 * ch, 32'({m_auto[ch], m_busy[ch]}));
        rd_chk("ch_count", 1'b0, 12 + 8 * ch, 32'(m_rem[ch]));
    endtask

    // One SDMA transfer: wait for Req, optionally answer Active, then pulse Done (unless held).
    task automatic serve(input int ch, input int adly, input int ddly, input bit skip_act, input bit hold);
        int n;
        n = 0;
        while (!req_m[ch] && n < 64) begin @(negedge clk); n++; end
        chk("req_seen", 32'(req_m[ch]), 32'd1);
        if (!skip_act) begin
            repeat (adly) @(negedge clk);
            act_m[ch] = 1'b1;
            @(negedge clk);
            act_m[ch] = 1'b0;
            chk("req_drop_on_active", 32'(req_m[ch]), 32'd0);
        end
        repeat (ddly) @(negedge clk);
        if (!hold) begin
            done_m[ch] = 1'b1;
            @(negedge clk);
            done_m[ch] = 1'b0;
            model_done(ch);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, n;
        bit anybusy;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset in the middle of a transfer.
        wr(4, 32'h1, 4'hF);
        set_count(0, 5, 4'hF);
        ctrl(0, 32'h1);
        serve(0, 0, 0, 1'b0, 1'b1);
        chk("busy_before_reset", 32'(busy_m), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_req", 32'(req_m), 32'd0);
        chk("rst_ack", 32'(ack_m), 32'd0);
        chk("rst_intr", 32'(intr_m), 32'd0);
        chk("rst_busy", 32'(busy_m), 32'd0);
        chk("rst_rdat", rd_m, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        rd_chk("rst_status", 1'b0, 0, 32'd0);
        rd_chk("rst_mask", 1'b0, 4, 32'd0);
        for (int ch = 0; ch < 4; ch++) check_ch(ch);

        // Single run of three transfers on ch0.
        set_count(0, 3, 4'hF);
        wr(4, 32'h1, 4'hF); m_mask = 4'h1;
        r0 = rise_m[0];
        ctrl(0, 32'h1);
        n = 0;
        while (m_busy[0] && n < 10) begin serve(0, 2, 4, 1'b0, 1'b0); n++; end
        @(negedge clk);
        chk("single_intr", 32'(intr_m), 32'd1);
        chk("single_busy", 32'(busy_m), 32'd0);
        repeat (3) @(negedge clk);
        chk("single_req_count", 32'(rise_m[0] - r0), 32'd3);
        rd_chk("single_status", 1'b0, 0, 32'(m_pend));
        w1c(4'h1);
        @(negedge clk);
        chk("single_intr_clr", 32'(intr_m), 32'd0);

        // Auto-reload on ch1, five Done pulses, then ABORT.
        set_count(1, 2, 4'hF);
        ctrl(1, 32'h3);
        for (int k = 1; k <= 5; k++) begin
            serve(1, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0);
            rd_chk("auto_status", 1'b0, 0, 32'(m_pend));
            if (m_pend[1]) w1c(4'h2);
        end
        check_ch(1);
        ctrl(1, 32'h4);
        chk("abort_req", 32'(req_m[1]), 32'd0);
        repeat (2) @(negedge clk);
        chk("abort_busy", 32'(busy_m), 32'd0);
        check_ch(1);
        rd_chk("abort_status", 1'b0, 0, 32'(m_pend));
        ctrl(1, 32'h5);
        repeat (2) @(negedge clk);
        chk("abort_start_busy", 32'(busy_m), 32'd0);

        // Four concurrent channels with counts 1..4, interrupt masked.
        wr(4, 32'h0, 4'hF); m_mask = 4'h0;
        for (int ch = 0; ch < 4; ch++) set_count(ch, ch + 1, 4'hF);
        for (int ch = 0; ch < 4; ch++) ctrl(ch, 32'h1);
        for (int r = 0; r < 4; r++) begin
            for (int ch = 0; ch < 4; ch++)
                if (m_busy[ch])
                    serve(ch, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0);
            rd_chk("conc_status", 1'b0, 0, 32'(m_pend));
            anybusy = 0;
            for (int ch = 0; ch < 4; ch++) anybusy |= m_busy[ch];
            chk("conc_busy", 32'(busy_m), 32'(anybusy));
            chk("conc_intr_masked", 32'(intr_m), 32'd0);
        end

        // Bus corners.
        w1c(4'hF);
        set_count(2, 0, 4'hF);
        ctrl(2, 32'h1);
        repeat (2) @(negedge clk);
        chk("zero_start_busy", 32'(busy_m), 32'd0);
        check_ch(2);
        set_count(3, 32'hABCD, 4'b0001);
        ctrl(3, 32'h1);
        check_ch(3);
        ctrl(3, 32'h4);
        rd_chk("unmapped_3c", 1'b0, 32'h3C, 32'd0);
        chk("rdat_idle", rd_m, 32'd0);
        wr(4, 32'h1, 4'hF); m_mask = 4'h1;
        set_count(0, 1, 4'hF);
        ctrl(0, 32'h1);
        serve(0, $urandom_range(0, 2), 0, 1'b0, 1'b1);
        done_m[0] = 1'b1;
        w1c(4'h1);
        model_done(0);
        rd_chk("set_beats_w1c", 1'b0, 0, 32'(m_pend));
        chk("set_beats_w1c_intr", 32'(intr_m), 32'd1);

        // Single-channel, 4-bit counter instance.
        bus(1'b1, 1'b1, 32'h0C, 32'h1F, 4'hF, wdat);
        bus(1'b1, 1'b1, 32'h14, 32'h5, 4'hF, wdat);
        bus(1'b1, 1'b1, 32'h10, 32'h3, 4'hF, wdat);
        repeat (2) @(negedge clk);
        chk("small_ch1_busy", 32'(busy_s), 32'd0);
        rd_chk("small_ch1_ctrl", 1'b1, 32'h10, 32'd0);
        rd_chk("small_ch1_count", 1'b1, 32'h14, 32'd0);
        r0 = rise_s;
        bus(1'b1, 1'b1, 32'h08, 32'h1, 4'hF, wdat);
        rd_chk("small_count_load", 1'b1, 32'h0C, 32'd15);
        for (int k = 0; k < 15; k++) begin
            n = 0;
            while (!req_s[0] && n < 64) begin @(negedge clk); n++; end
            chk("small_req_seen", 32'(req_s[0]), 32'd1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            act_s = 1'b1; @(negedge clk); act_s = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            done_s = 1'b1; @(negedge clk); done_s = 1'b0;
        end
        repeat (3) @(negedge clk);
        chk("small_req_count", 32'(rise_s - r0), 32'd15);
        chk("small_busy", 32'(busy_s), 32'd0);
        rd_chk("small_status", 1'b1, 32'h00, 32'd1);
        rd_chk("small_count_end", 1'b1, 32'h0C, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
